// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues one outstanding imem fetch, loads IF/ID.
// Define MISALIGN_TRAP_EN to trap on redirect targets with bit 1 set.
module fetch_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            clk_en,
    input  logic            rst_n,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] jump_address,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic            misaligned_trap
);

`ifdef MISALIGN_TRAP_EN
    typedef enum logic [2:0] {
        ST_BOOT, ST_REQ, ST_WAIT, ST_HOLD, ST_TRAP
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_BOOT, ST_REQ, ST_WAIT, ST_HOLD
    } state_t;
`endif

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc, inflight_pc, skid_instr;
    logic [XLEN-1:0] target, pc_seq;
    logic            kill, free, redirect, granted;
    logic            rsp_seen, take_rsp, take_skid;
    logic            unused_bits;
`ifdef MISALIGN_TRAP_EN
    logic            bad_target;
`endif

    assign unused_bits = ^jump_address[1:0];

    always_comb begin
        free     = !if_id_valid || !stall;
        redirect = branch_taken && if_id_valid && !stall;
        granted  = (state == ST_REQ) && imem_gnt;
        pc_seq   = inflight_pc + XLEN'(4);
`ifdef MISALIGN_TRAP_EN
        target     = {jump_address[XLEN-1:1], 1'b0};
        bad_target = target[1];
        // TRAP still drains a response that was granted before the trap
        rsp_seen   = imem_rvalid
                     && (state == ST_WAIT || state == ST_TRAP);
`else
        target   = {jump_address[XLEN-1:2], 2'b00};
        rsp_seen = imem_rvalid && (state == ST_WAIT);
`endif
        take_rsp  = rsp_seen && (state == ST_WAIT) && !kill
                    && free && !redirect;
        take_skid = (state == ST_HOLD) && free && !redirect;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_BOOT;
        end else if (clk_en) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_BOOT: state_nxt = ST_REQ;
            ST_REQ:  if (imem_gnt) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = (kill || free) ? ST_REQ : ST_HOLD;
                end
            end
            ST_HOLD: if (free) state_nxt = ST_REQ;
            default: state_nxt = state;
        endcase
`ifdef MISALIGN_TRAP_EN
        if (redirect && bad_target) state_nxt = ST_TRAP;
`endif
    end

    always_comb begin
        imem_req  = clk_en && (state == ST_REQ);
        imem_addr = pc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight_pc <= RESET_PC;
            skid_instr  <= NOP_INSTR;
            kill        <= 1'b0;
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
        end else if (clk_en) begin
            if (granted) inflight_pc <= pc;
            if (state == ST_WAIT && imem_rvalid) begin
                skid_instr <= imem_rdata;
            end

            if (redirect) begin
                pc <= target;
            end else if (take_rsp || take_skid) begin
                pc <= pc_seq;
            end

            // a still-outstanding request must be dropped on arrival
            if (redirect && (granted
                    || (state == ST_WAIT && !imem_rvalid))) begin
                kill <= 1'b1;
            end else if (rsp_seen) begin
                kill <= 1'b0;
            end

            if (redirect) begin
                if_id_valid <= 1'b0;
                if_id_instr <= NOP_INSTR;
            end else if (take_rsp) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= inflight_pc;
                if_id_instr <= imem_rdata;
            end else if (take_skid) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= inflight_pc;
                if_id_instr <= skid_instr;
            end else if (free) begin
                if_id_valid <= 1'b0;
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misaligned_trap <= 1'b0;
        end else if (clk_en && redirect && bad_target) begin
            misaligned_trap <= 1'b1;
        end
    end
`else
    assign misaligned_trap = 1'b0;
`endif

endmodule
